// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared constants and types for the sequential divider.
// Holds the default operand width, the iteration-counter width helper and the FSM state type.
// Used by seq_divider and div_step; build option SEQ_DIVIDER_EARLY_EXIT_EN lives in seq_divider.
package seq_divider_pkg;

  // Default operand width: dividend is 2*DEF_W bits, divisor/quotient/remainder DEF_W bits.
  localparam int DEF_W = 32;

  // Iteration counter must hold 0..W-1 with headroom, hence clog2(W)+1 bits.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_W);

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division step (shift, trial subtract, select).
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to register the result.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
  // The partial remainder stays below the divisor, so the shifted value is < 2*divisor and
  // a successful subtraction always fits in W bits; only the compare needs the extra bit.
  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    fits    = (shifted >= {1'b0, divisor_i});
    diff    = shifted[W-1:0] - divisor_i;
  end

  // Restore on a negative trial result, otherwise keep the difference and set the quotient bit.
  always_comb begin
    rem_o = shifted[W-1:0];
    quo_o = {quo_i[W-2:0], 1'b0};
    if (fits) begin
      rem_o = diff;
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned 2W/W sequential restoring divider with div-by-zero and overflow flags.
// Latency: W+1 edges from the accept edge (inclusive) to out_valid; errors take 1 edge when
// SEQ_DIVIDER_EARLY_EXIT_EN is defined. Backpressure: result held in DONE until out_ready.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Working registers: acc_hi_q is the partial remainder, acc_lo_q shifts out dividend bits
  // and shifts in quotient bits.
  logic [W-1:0]     acc_hi_q;
  logic [W-1:0]     acc_lo_q;
  logic [W-1:0]     dvsr_q;
  logic             pend_dbz_q;
  logic             pend_ovf_q;

  // Result registers, only written when a result is produced.
  logic [W-1:0]     quo_q;
  logic [W-1:0]     rem_q;
  logic             dbz_q;
  logic             ovf_q;

  logic             dbz_d;
  logic             ovf_d;
  logic [W-1:0]     step_rem_d;
  logic [W-1:0]     step_quo_d;
  logic             pend_err;
  logic             last_step;

  // Classify the request at accept time; div-by-zero masks overflow so the flags never coexist.
  always_comb begin
    dbz_d = (divisor == '0);
    ovf_d = !dbz_d && (dividend[2*W-1:W] >= divisor);
  end

  assign pend_err  = pend_dbz_q | pend_ovf_q;
  assign last_step = (cnt_q == LAST_CNT);

  div_step #(
    .W (W)
  ) u_div_step (
    .rem_i     (acc_hi_q),
    .quo_i     (acc_lo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem_d),
    .quo_o     (step_quo_d)
  );

  // Controller FSM plus all datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      dvsr_q     <= '0;
      pend_dbz_q <= 1'b0;
      pend_ovf_q <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_hi_q   <= dividend[2*W-1:W];
            acc_lo_q   <= dividend[W-1:0];
            dvsr_q     <= divisor;
            cnt_q      <= '0;
            pend_dbz_q <= dbz_d;
            pend_ovf_q <= ovf_d;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
            // Erroring requests skip the iterations; the forced result is known right now.
            if (dbz_d || ovf_d) begin
              state_q <= DONE;
              quo_q   <= '1;
              rem_q   <= dividend[W-1:0];
              dbz_q   <= dbz_d;
              ovf_q   <= ovf_d;
            end else begin
              state_q <= RUN;
            end
`else
            state_q <= RUN;
`endif
          end
        end

        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Freeze the accumulator on error so acc_lo_q still holds dividend[W-1:0] at the end.
          if (!pend_err) begin
            acc_hi_q <= step_rem_d;
            acc_lo_q <= step_quo_d;
          end
          if (last_step) begin
            state_q <= DONE;
            dbz_q   <= pend_dbz_q;
            ovf_q   <= pend_ovf_q;
            if (pend_err) begin
              quo_q <= '1;
              rem_q <= acc_lo_q;
            end else begin
              quo_q <= step_quo_d;
              rem_q <= step_rem_d;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (W=32).
// Expected results come from a behavioural divide model pushed at drive time.
// Honours SEQ_DIVIDER_EARLY_EXIT_EN for the error-path latency.
module tb_seq_divider;

  localparam int W = 32;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  localparam int ERR_LAT = 1;
`else
  localparam int ERR_LAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  always #5 clk = ~clk;

  seq_divider #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    exp_t           e;
    logic [2*W-1:0] qq;
    logic [2*W-1:0] rr;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 1;
    if (dv == '0) begin
      e.dbz = 1'b1;
      e.q   = '1;
      e.r   = dd[W-1:0];
      e.lat = ERR_LAT;
    end else if (dd[2*W-1:W] >= dv) begin
      e.ovf = 1'b1;
      e.q   = '1;
      e.r   = dd[W-1:0];
      e.lat = ERR_LAT;
    end else begin
      qq  = dd / {{W{1'b0}}, dv};
      rr  = dd % {{W{1'b0}}, dv};
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
    end
    return e;
  endfunction

  // Called at a negedge: record the expectation and present the request.
  task automatic push_drive(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    sb_q.push_back(model(dd, dv));
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
  endtask

  // Called at a negedge with a request presented: wait for accept, count edges to out_valid
  // (accept edge counts as 1), keep garbage requests on the inputs meanwhile, then compare.
  task automatic wait_result(input string tag);
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    chk({tag, ".accept"}, in_ready, 1'b1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = sb_q.pop_front();
    chk({tag, ".lat"}, lat, e.lat);
    chk({tag, ".q"},   quotient, e.q);
    chk({tag, ".r"},   remainder, e.r);
    chk({tag, ".dbz"}, div_by_zero, e.dbz);
    chk({tag, ".ovf"}, overflow, e.ovf);
  endtask

  // Handshake the held result and confirm the block is idle again.
  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".rel_ov"}, out_valid, 1'b0);
    chk({tag, ".rel_ir"}, in_ready, 1'b1);
  endtask

  task automatic full_req(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    push_drive(dd, dv);
    wait_result(tag);
    release_result(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rdv;
    logic [W-1:0] rhi;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.q", quotient, 0);
    chk("rst.r", remainder, 0);
    chk("rst.dbz", div_by_zero, 1'b0);
    chk("rst.ovf", overflow, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    full_req("d100_7", 64'd100, 32'd7);
    full_req("dmax", 64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
    full_req("dbz", 64'h1234, 32'd0);
    full_req("ovf", 64'h00000005_00000000, 32'd5);
    full_req("hi_lt", 64'h00000006_FFFFFFFF, 32'd7);
    full_req("zero", 64'd0, 32'd1);
    full_req("div1", 64'h00000000_DEADBEEF, 32'd1);

    for (int i = 0; i < 6; i++) begin
      rdv = $urandom | 32'h1;
      rhi = $urandom % rdv;
      full_req($sformatf("rnd%0d", i), {rhi, 32'($urandom)}, rdv);
    end

    // Backpressure: hold the 1000/3 result for 10 cycles while a second request waits.
    push_drive(64'd1000, 32'd3);
    wait_result("bp");
    push_drive(64'd77, 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold_ov", out_valid, 1'b1);
      chk("bp.hold_ir", in_ready, 1'b0);
      chk("bp.hold_q", quotient, 333);
      chk("bp.hold_r", remainder, 1);
      chk("bp.hold_flags", {div_by_zero, overflow}, 2'b00);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.hs_ir", in_ready, 1'b1);
    chk("bp.hs_ov", out_valid, 1'b0);
    wait_result("bp2");
    release_result("bp2");

    // Reset during RUN aborts silently; a fresh request afterwards still works.
    in_valid = 1'b1;
    dividend = 64'd100;
    divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abort.running", in_ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort.ir", in_ready, 1'b1);
    chk("abort.ov", out_valid, 1'b0);
    chk("abort.q", quotient, 0);
    chk("abort.r", remainder, 0);
    chk("abort.flags", {div_by_zero, overflow}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    full_req("post_abort", 64'd100, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
